// File: rtl/serial_twos_pkg.sv
// Shared types and op-code constants for the bit-serial two's-complement engine.
package serial_twos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } st_e;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_NEG  = 2'b01;
  localparam logic [1:0] OP_ABS  = 2'b10;

  // Whether an op complements the operand (and injects the +1 carry).
  // ABS only inverts negative operands; the reserved code behaves as pass.
  function automatic logic inv_for(input logic [1:0] op, input logic msb);
    case (op)
      OP_NEG:  inv_for = 1'b1;
      OP_ABS:  inv_for = msb;
      default: inv_for = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder shared by the serial datapath.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic carry
);

  assign sum   = A ^ B ^ Cin;
  assign carry = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_twos_ctrl.sv
// Bit-serial pass/negate/abs engine: one full adder, LSB-first over WIDTH cycles,
// operand in via valid/ready, result held on out_valid until accepted.
module serial_twos_ctrl
  import serial_twos_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  st_e              st, st_nxt;
  logic [WIDTH-1:0] opnd, res;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             invert, carry_reg, orig_msb;
  logic             fa_a, fa_sum, fa_co;
  logic             accept, last_bit;

  assign accept   = (st == IDLE) && in_valid;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // B is tied low: the adder only propagates the +1 carry through the
  // (optionally inverted) operand bits.
  assign fa_a = opnd[0] ^ invert;

  full_adder u_fa (
    .A     (fa_a),
    .B     (1'b0),
    .Cin   (carry_reg),
    .sum   (fa_sum),
    .carry (fa_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Next-state decode; in_valid only matters in IDLE, out_ready only in DONE.
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (in_valid)  st_nxt = RUN;
      RUN:     if (last_bit)  st_nxt = DONE;
      DONE:    if (out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Operand capture and one-bit-per-cycle shift; final carry-out is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd      <= '0;
      res       <= '0;
      cnt       <= '0;
      op_q      <= OP_PASS;
      invert    <= 1'b0;
      carry_reg <= 1'b0;
      orig_msb  <= 1'b0;
    end else if (accept) begin
      opnd      <= in_data;
      op_q      <= in_op;
      invert    <= inv_for(in_op, in_data[WIDTH-1]);
      carry_reg <= inv_for(in_op, in_data[WIDTH-1]);
      orig_msb  <= in_data[WIDTH-1];
      cnt       <= '0;
    end else if (st == RUN) begin
      res       <= {fa_sum, res[WIDTH-1:1]};
      opnd      <= opnd >> 1;
      carry_reg <= fa_co;
      cnt       <= cnt + 1'b1;
    end
  end

  // Outputs decode from state and registers only. Overflow uses the sign rule:
  // inverting a negative operand must give a non-negative result.
  assign in_ready  = (st == IDLE);
  assign busy      = (st == RUN) || (st == DONE);
  assign out_valid = (st == DONE);
  assign out_data  = res;
  assign out_ovf   = (st == DONE) && invert && orig_msb && res[WIDTH-1];

endmodule

// File: tb/tb_serial_twos_ctrl.sv
// Directed bench for serial_twos_ctrl (WIDTH=8) with hand-computed expectations.
module tb_serial_twos_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_twos_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; n = edges elapsed.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Single transaction with out_ready held high.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] d,
                        input logic [W-1:0] exp_d, input logic exp_o);
    int n;
    in_op = op; in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
    chk({tag, "_ovf"},  32'(out_ovf),  32'(exp_o));
    tick();
  endtask

  initial begin
    int n;
    // Reset state
    tick(); tick();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    tick();

    // Latency: negate 0x05
    in_op = 2'b01; in_data = 8'h05; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_busy", 32'(busy), 32'd1);
    wait_out(n);
    chk("lat_edges", 32'(n), 32'd8);
    chk("neg05_data", 32'(out_data), 32'hFB);
    chk("neg05_ovf",  32'(out_ovf),  32'd0);
    tick();
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    chk("lat_out_valid_drop", 32'(out_valid), 32'd0);

    run_op("neg00",  2'b01, 8'h00, 8'h00, 1'b0);
    run_op("neg80",  2'b01, 8'h80, 8'h80, 1'b1);
    run_op("abs80",  2'b10, 8'h80, 8'h80, 1'b1);
    run_op("absFB",  2'b10, 8'hFB, 8'h05, 1'b0);
    run_op("abs7F",  2'b10, 8'h7F, 8'h7F, 1'b0);
    run_op("passA5", 2'b00, 8'hA5, 8'hA5, 1'b0);
    run_op("rsv3C",  2'b11, 8'h3C, 8'h3C, 1'b0);

    // Backpressure
    out_ready = 1'b0;
    in_op = 2'b01; in_data = 8'h01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_data = 8'h22; in_valid = 1'b1; end
      else in_valid = 1'b0;
      chk("bp_data",     32'(out_data),  32'hFF);
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_busy",     32'(busy),      32'd1);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_data_end", 32'(out_data), 32'hFF);
    out_ready = 1'b1;
    tick();
    chk("bp_consumed", 32'(out_valid), 32'd0);
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Reset mid-RUN
    in_op = 2'b01; in_data = 8'h33; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy",     32'(busy),      32'd0);
    chk("arst_in_ready", 32'(in_ready),  32'd1);
    chk("arst_valid",    32'(out_valid), 32'd0);
    chk("arst_data",     32'(out_data),  32'd0);
    chk("arst_ovf",      32'(out_ovf),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("neg10", 2'b01, 8'h10, 8'hF0, 1'b0);

    // Back-to-back with in_valid held
    in_op = 2'b01; in_data = 8'h01; in_valid = 1'b1;
    tick();
    in_data = 8'h02;
    wait_out(n);
    chk("b2b_first", 32'(out_data), 32'hFF);
    n = n + 1;
    tick();
    while (!busy && n < 40) begin tick(); n++; end
    chk("b2b_second_accept_edge", 32'(n), 32'd10);
    in_valid = 1'b0;
    wait_out(n);
    chk("b2b_second", 32'(out_data), 32'hFE);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
